ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

Core-side PS/2 keyboard receiver: consumes the emulated `ps2_kbd_clk`/`ps2_kbd_data` pair driven by the IO controller block and turns it into decoded key events. It has three stages:
- Synchronise and deglitch both lines.
- Deserialise 11-bit PS/2 frames and check parity and stop bit.
- Fold `E0` (extended) and `F0` (break) prefixes into each following scan code, then buffer the events in a small show-ahead FIFO read by the keyboard matrix logic.

## Interface
- `FILTER`, 8: consecutive `clk_sys` cycles the synchronised clock line must hold a new level before it is accepted.
- `TIMEOUT`, 2000: `clk_sys` cycles without a filtered falling edge, mid-frame, before the frame is aborted.
- `FIFO_BITS`, 2: log2 of event FIFO depth (default depth 4).
- `clk_sys`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  PS/2 clock line, asynchronous, idles high.
- `ps2_data`  in  1  PS/2 data line, asynchronous.
- `rx_byte`  out  8  last correctly received raw byte; reset 0.
- `rx_strobe`  out  1  one-cycle pulse when `rx_byte` updates; reset 0.
- `parity_err`  out  1  one-cycle pulse on a parity failure; reset 0.
- `frame_err`  out  1  one-cycle pulse on a bad start bit, bad stop bit or timeout; reset 0.
- `key_valid`  out  1  FIFO not empty; reset 0.
- `key_code`  out  8  scan code at FIFO head; reset 0.
- `key_ext`  out  1  head event carried an `E0` prefix; reset 0.
- `key_rel`  out  1  head event carried an `F0` prefix (key release); reset 0.
- `key_rd`  in  1  pop the head when `key_valid`; ignored when the FIFO is empty.
- `overflow`  out  1  sticky, set when an event is dropped on a full FIFO; cleared only by `reset`.

## Operation
- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through 2 flops.
- **Clock filter:** the filtered clock register takes the synchronised clock level once that level has differed from it for `FILTER` consecutive cycles. The filter counter restarts whenever the synchronised level equals the filtered level. Reset value of the filtered clock is 1.
- **Sampling:** a falling edge of the filtered clock samples the synchronised data.
- **Deserialiser states:** IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge, data 0 → DATA with bit count 0. Data 1 → `frame_err` pulse, stay in IDLE.
  - DATA: shift the 8 data bits in LSB first, then → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: data 1 and odd parity over the 8 data bits plus the parity bit → deliver the byte. Stop bit 0 → `frame_err`. Parity bad with stop bit 1 → `parity_err`. Return to IDLE in all cases.
- **Timeout:** in DATA, PARITY or STOP, the counter reloads on each edge. Reaching `TIMEOUT` → `frame_err`, IDLE, partial byte discarded.
- **Decoder:**
  - On delivery of `E0`: set the ext flag.
  - On delivery of `F0`: set the rel flag.
  - Any other byte: write {ext, rel, byte} to the FIFO, then clear both flags.
  - Any `parity_err` or `frame_err` also clears both flags.
  - `E1` and `AA` are ordinary codes.
- **FIFO:** show-ahead. The `key_*` outputs show the head whenever `key_valid` is 1. `key_code`, `key_ext` and `key_rel` are don't-care when `key_valid` is 0.
- **Full FIFO:**
  - A write with no simultaneous pop is dropped and sets `overflow`.
  - A write with a simultaneous pop is accepted and the count is unchanged.
  - Pointers wrap modulo depth.
- **Reset mid-frame:** state IDLE, counters 0, flags cleared, FIFO emptied, and all outputs return to their reset values in the cycle after `reset` is sampled high.

## Timing
- Edge detection latency: a line change reaches the filtered clock 2 (synchroniser) + `FILTER` cycles later.
- `rx_strobe`, `parity_err` and `frame_err` assert on the cycle after the sampling edge that completes or fails the frame.
- The FIFO write occurs on the `rx_strobe` cycle. `key_valid` rises the next cycle.
- `key_rd` is sampled on a rising edge. The head advances, or `key_valid` falls, on the following cycle.
- Edge rate: the source delivers one bit per 2×PS2DIV `clk_sys` cycles (200 at PS2DIV=100). `FILTER` must stay below PS2DIV/2 and `TIMEOUT` above 4×PS2DIV.

## Test plan
- Send frame `0x1C` (parity 0, stop 1) → one `rx_strobe` with `rx_byte`=`1C`; FIFO event code `1C`, ext 0, rel 0.
- Send `E0` `F0` `75` → three `rx_strobe` pulses, exactly one FIFO event: code `75`, ext 1, rel 1. A following `75` alone gives an event with ext 0, rel 0.
- Send `F0` with wrong parity, then `1C` → `parity_err` pulse, no `rx_strobe` for the bad frame, single event code `1C` with rel 0.
- Stop clocking after 5 bits for `TIMEOUT`+10 cycles → one `frame_err` pulse. A following good `0x29` is received correctly.
- Send 5 make codes `15`,`1D`,`24`,`2D`,`2C` with `key_rd`=0 → `overflow`=1 and 4 events (`15`..`2D`). Popping all of them gives `key_valid`=0 after the 4th pop. A `key_rd` pulse while empty causes no change.
- Inject 3-cycle low glitches on `ps2_clk` in IDLE and mid-frame → no edge detected; byte `0x5A` is still received intact.

Source files
------------

// File: rtl/ps2_kbd_rx_if.sv
// rtl/ps2_kbd_rx_if.sv - decoded key event port between the PS/2 receiver and its reader
interface ps2_kbd_rx_if;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_rel;
  logic       key_rd;

  modport master (output key_valid, key_code, key_ext, key_rel, input key_rd);
  modport slave  (input key_valid, key_code, key_ext, key_rel, output key_rd);
endinterface

// File: rtl/ps2_kbd_rx.sv
// rtl/ps2_kbd_rx.sv - PS/2 keyboard receiver: line filter, frame deserialiser, E0/F0 folding, event FIFO
module ps2_kbd_rx #(
  parameter int FILTER    = 8,
  parameter int TIMEOUT   = 2000,
  parameter int FIFO_BITS = 2
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [7:0]       rx_byte,
  output logic             rx_strobe,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overflow,
  ps2_kbd_rx_if.master     key
);

  localparam int DEPTH = 1 << FIFO_BITS;
  localparam int FW    = $clog2(FILTER + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0]        FILT_LAST = FW'(FILTER - 1);
  localparam logic [TW-1:0]        TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [FIFO_BITS:0]   FULL_CNT  = (FIFO_BITS+1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      dat_s1    <= 1'b1;
      dat_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= ps2_clk;
      clk_s2    <= clk_s1;
      dat_s1    <= ps2_data;
      dat_s2    <= dat_s1;
      filt_prev <= filt_clk;
      // A new clock level is only believed after FILTER unbroken cycles.
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = filt_prev & ~filt_clk;

  state_t        state_q, state_d;
  logic [7:0]    shreg_q, shreg_d, byte_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          strobe_d, perr_d, ferr_d;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    to_cnt_d  = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
    byte_d    = rx_byte;
    strobe_d  = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      ST_IDLE: if (fall) begin
        if (!dat_s2) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          ferr_d = 1'b1;
        end
      end
      ST_DATA: if (fall) begin
        shreg_d   = {dat_s2, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
      end
      ST_PARITY: if (fall) begin
        par_d   = dat_s2;
        state_d = ST_STOP;
      end
      ST_STOP: if (fall) begin
        state_d = ST_IDLE;
        if (!dat_s2) begin
          ferr_d = 1'b1;
        end else if (^{shreg_q, par_q}) begin
          strobe_d = 1'b1;
          byte_d   = shreg_q;
        end else begin
          perr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled frame is abandoned; an edge arriving on the same cycle wins.
    if (state_q != ST_IDLE && !fall && to_cnt_q == TO_LAST) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      rx_byte    <= '0;
      rx_strobe  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      par_q      <= par_d;
      to_cnt_q   <= to_cnt_d;
      rx_byte    <= byte_d;
      rx_strobe  <= strobe_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

  logic                 ext_q, rel_q;
  logic [9:0]           mem [DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr, rd_ptr;
  logic [FIFO_BITS:0]   count;
  logic                 is_prefix, wr, pop, full, accept;
  logic [9:0]           head;

  assign is_prefix = (rx_byte == 8'hE0) || (rx_byte == 8'hF0);
  assign wr        = rx_strobe && !is_prefix;
  assign pop       = key.key_rd && (count != '0);
  assign full      = (count == FULL_CNT);
  assign accept    = wr && (!full || pop);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (parity_err || frame_err) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end else if (rx_strobe) begin
        if (rx_byte == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (rx_byte == 8'hF0) begin
          rel_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          rel_q <= 1'b0;
        end
      end
      if (wr && full && !pop) overflow <= 1'b1;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (accept) mem[wr_ptr] <= {ext_q, rel_q, rx_byte};
  end

  assign head          = mem[rd_ptr];
  assign key.key_valid = (count != '0);
  assign key.key_code  = key.key_valid ? head[7:0] : 8'h00;
  assign key.key_rel   = key.key_valid & head[8];
  assign key.key_ext   = key.key_valid & head[9];

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb/tb_ps2_kbd_rx.sv - randomised and directed PS/2 frames against a queue-based event model
module tb_ps2_kbd_rx;
  localparam int PS2DIV  = 25;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 2000;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_strobe, parity_err, frame_err, overflow;
  logic       rd_man = 1'b0;
  logic       rd_rand = 1'b0;
  logic       rd_en = 1'b0;

  ps2_kbd_rx_if kif ();
  assign kif.key_rd = rd_man | rd_rand;

  ps2_kbd_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_BITS(2)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .rx_strobe  (rx_strobe),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .key        (kif.master)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // kind: 0 = good byte, 1 = parity error, 2 = frame error
  typedef struct {
    int         kind;
    logic [7:0] b;
  } exp_t;

  exp_t       expq[$];
  logic [9:0] fifo_m[$];
  logic       m_ext = 1'b0;
  logic       m_rel = 1'b0;
  logic       m_ovf = 1'b0;

  always @(negedge clk_sys) begin
    exp_t e;
    int   obs;
    logic w;
    logic [9:0] wv;
    logic p, f;
    if (reset) begin
      expq.delete();
      fifo_m.delete();
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_ovf = 1'b0;
    end else begin
      w  = 1'b0;
      wv = '0;
      if (rx_strobe || parity_err || frame_err) begin
        obs = (rx_strobe + parity_err + frame_err > 1) ? 9 : (parity_err ? 1 : (frame_err ? 2 : 0));
        if (expq.size() == 0) begin
          check("unexpected_pulse", obs, 32'hFF);
        end else begin
          e = expq.pop_front();
          check("event_kind", obs, e.kind);
          if (e.kind == 0) begin
            check("rx_byte", rx_byte, e.b);
            if (e.b == 8'hE0) m_ext = 1'b1;
            else if (e.b == 8'hF0) m_rel = 1'b1;
            else begin
              w = 1'b1;
              wv = {m_ext, m_rel, e.b};
              m_ext = 1'b0;
              m_rel = 1'b0;
            end
          end else begin
            m_ext = 1'b0;
            m_rel = 1'b0;
          end
        end
      end
      check("key_valid", kif.key_valid, fifo_m.size() > 0);
      if (fifo_m.size() > 0) begin
        check("key_code", kif.key_code, fifo_m[0][7:0]);
        check("key_rel", kif.key_rel, fifo_m[0][8]);
        check("key_ext", kif.key_ext, fifo_m[0][9]);
      end
      check("overflow", overflow, m_ovf);
      p = kif.key_rd && (fifo_m.size() > 0);
      f = (fifo_m.size() == 4);
      if (w && f && !p) m_ovf = 1'b1;
      if (p) void'(fifo_m.pop_front());
      if (w && (!f || p)) fifo_m.push_back(wv);
    end
  end

  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      rd_rand = rd_en && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    wait_cyc(12);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(10);
    end
    ps2_data = b;
    wait_cyc(12);
    ps2_clk = 1'b0;
    wait_cyc(PS2DIV);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic [10:0] fr;
    exp_t e;
    fr = {1'b1, bad_par ? ^b : ~^b, b, 1'b0};
    e.kind = bad_par ? 1 : 0;
    e.b = b;
    expq.push_back(e);
    for (int i = 0; i < 11; i++) send_bit(fr[i], glitch && (i == 4));
    ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_partial(input int nbits);
    logic [7:0] junk;
    junk = 8'($urandom);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits - 1; i++) send_bit(junk[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  task automatic pop_one();
    wait_cyc(1);
    rd_man = 1'b1;
    wait_cyc(1);
    rd_man = 1'b0;
  endtask

  task automatic expect_head(input string name, input logic [7:0] code, input logic ext, input logic rel);
    @(negedge clk_sys);
    check({name, "_valid"}, kif.key_valid, 1);
    check({name, "_code"}, kif.key_code, code);
    check({name, "_ext"}, kif.key_ext, ext);
    check({name, "_rel"}, kif.key_rel, rel);
  endtask

  task automatic drained(input string name);
    check(name, expq.size(), 0);
  endtask

  initial begin
    logic [7:0] pre_codes [5];
    logic [7:0] c;
    pre_codes[0] = 8'h15; pre_codes[1] = 8'h1D; pre_codes[2] = 8'h24;
    pre_codes[3] = 8'h2D; pre_codes[4] = 8'h2C;

    wait_cyc(4);
    reset = 1'b0;
    @(negedge clk_sys);
    check("rst_rx_byte", rx_byte, 0);
    check("rst_rx_strobe", rx_strobe, 0);
    check("rst_key_valid", kif.key_valid, 0);
    check("rst_key_code", kif.key_code, 0);
    check("rst_overflow", overflow, 0);

    send_frame(8'h1C, 0, 0);
    drained("t1_drained");
    expect_head("t1", 8'h1C, 0, 0);
    pop_one();

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    drained("t2_drained");
    expect_head("t2", 8'h75, 1, 1);
    pop_one();
    @(negedge clk_sys);
    check("t2_single_event", kif.key_valid, 0);
    send_frame(8'h75, 0, 0);
    expect_head("t2b", 8'h75, 0, 0);
    pop_one();

    send_frame(8'hF0, 1, 0);
    send_frame(8'h1C, 0, 0);
    drained("t3_drained");
    expect_head("t3", 8'h1C, 0, 0);
    pop_one();

    begin
      exp_t e;
      e.kind = 2;
      e.b = 8'h00;
      expq.push_back(e);
    end
    send_partial(5);
    wait_cyc(TIMEOUT + 10);
    drained("t4_timeout");
    send_frame(8'h29, 0, 0);
    expect_head("t4", 8'h29, 0, 0);
    check("t4_rx_byte", rx_byte, 8'h29);
    pop_one();

    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    send_frame(8'h5A, 0, 1);
    drained("t5_glitch");
    expect_head("t5", 8'h5A, 0, 0);
    pop_one();

    for (int i = 0; i < 5; i++) send_frame(pre_codes[i], 0, 0);
    @(negedge clk_sys);
    check("t6_overflow", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      expect_head("t6_pop", pre_codes[i], 0, 0);
      pop_one();
    end
    @(negedge clk_sys);
    check("t6_empty", kif.key_valid, 0);
    pop_one();
    @(negedge clk_sys);
    check("t6_empty_rd", kif.key_valid, 0);
    check("t6_overflow_sticky", overflow, 1);

    rd_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 2) == 0) send_frame(8'hE0, 0, 0);
      if ($urandom_range(0, 1) == 0) send_frame(8'hF0, 0, 0);
      c = 8'($urandom);
      if (c == 8'hE0 || c == 8'hF0) c = 8'h1C;
      send_frame(c, $urandom_range(0, 7) == 0, 0);
    end
    rd_en = 1'b0;
    wait_cyc(4);
    drained("rand_drained");

    send_partial(4);
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(2);
    reset = 1'b0;
    @(negedge clk_sys);
    check("mrst_key_valid", kif.key_valid, 0);
    check("mrst_overflow", overflow, 0);
    check("mrst_rx_byte", rx_byte, 0);
    send_frame(8'h1C, 0, 0);
    expect_head("mrst", 8'h1C, 0, 0);
    drained("final_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
